// File: rtl/wave_classifier.sv
// -----------------------------------------------------------------------------
// wave_classifier
//
// Watches a 5-bit sample stream from a signal generator and decides whether it
// is a square, sawtooth or triangle wave. Once the stream is consistent with
// exactly one class for LOCK_CNT consecutive steps, the block locks and
// measures the period between successive anchor events of that class.
//
// Ports
//   clk         in   1  clock, all flops on rising edge
//   rst_n       in   1  asynchronous active-low reset
//   wave_en     in   1  sample qualifier; wave is only looked at while high
//   wave        in   5  unsigned sample 0..31
//   wave_type   out  2  0 square, 1 sawtooth, 2 triangle, 3 unknown
//   locked      out  1  high while wave_type holds a valid class
//   period      out  8  last measured period in samples, saturates at 255
//   period_vld  out  1  one-cycle pulse when period loads
//   err         out  1  one-cycle pulse when lock is lost
//
// State | meaning
// ------+----------------------------------------------------------------
// HUNT  | narrowing the hypothesis mask, no class reported
// LOCK  | one class confirmed; anchors of that class drive the period meter
// -----------------------------------------------------------------------------
module wave_classifier #(
    parameter int unsigned LOCK_CNT = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wave_en,
    input  logic [4:0] wave,
    output logic [1:0] wave_type,
    output logic       locked,
    output logic [7:0] period,
    output logic       period_vld,
    output logic       err
);

    typedef enum logic {
        HUNT = 1'b0,
        LOCK = 1'b1
    } state_t;

    localparam logic [1:0] CLS_SQ      = 2'd0;
    localparam logic [1:0] CLS_SAW     = 2'd1;
    localparam logic [1:0] CLS_TRI     = 2'd2;
    localparam logic [1:0] CLS_UNKNOWN = 2'd3;

    state_t      state;
    logic [4:0]  prev;
    logic        prev_ok;
    logic        last_up;
    logic        dir_vld;
    logic [2:0]  mask;
    logic [3:0]  cnt;
    logic [7:0]  pcnt;
    logic        armed;

    logic [5:0]  d;
    logic        st_hold;
    logic        st_up;
    logic        st_dn;
    logic        st_jup;
    logic        st_jdn;
    logic        at_rail;
    logic        reversal;
    logic [2:0]  cons;
    logic [2:0]  anc;
    logic [2:0]  mask_and;
    logic [2:0]  mask_nxt;
    logic [3:0]  cnt_nxt;
    logic        one_hot;
    logic [1:0]  new_cls;
    logic        lock_hit;
    logic        cls_ok;
    logic        cls_anc;
    logic        anc_clr;
    logic [7:0]  pcnt_inc;

    // Pick bit i of a per-class vector; the "unknown" code selects nothing.
    function automatic logic sel_cls(input logic [2:0] v, input logic [1:0] i);
        logic r;
        r = 1'b0;
        case (i)
            CLS_SQ:  r = v[0];
            CLS_SAW: r = v[1];
            CLS_TRI: r = v[2];
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    always_comb begin
        d        = {1'b0, wave} - {1'b0, prev};
        st_hold  = (d == 6'd0);
        st_up    = (d == 6'd1);
        st_dn    = (d == 6'h3f);
        st_jup   = (prev == 5'd0)  && (wave == 5'd31);
        st_jdn   = (prev == 5'd31) && (wave == 5'd0);
        at_rail  = (prev == 5'd0) || (prev == 5'd31);

        // A triangle may only turn around at the rails.
        reversal = dir_vld && ((st_up && !last_up) || (st_dn && last_up));

        cons[0]  = (st_hold && at_rail) || st_jup || st_jdn;
        cons[1]  = st_up || st_jdn;
        cons[2]  = (st_up || st_dn) && (!reversal || at_rail);

        anc[0]   = st_jup;
        anc[1]   = st_jdn;
        anc[2]   = st_up && (wave == 5'd31);

        mask_and = mask & cons;
        if (mask_and != 3'b000) begin
            mask_nxt = mask_and;
            cnt_nxt  = (cnt == 4'd15) ? 4'd15 : cnt + 4'd1;
        end else begin
            // Every hypothesis died: restart from what this step alone allows.
            mask_nxt = cons;
            cnt_nxt  = {3'b000, |cons};
        end

        one_hot = (mask_nxt == 3'b001) || (mask_nxt == 3'b010) || (mask_nxt == 3'b100);

        new_cls = CLS_SQ;
        if (mask_nxt[1]) begin
            new_cls = CLS_SAW;
        end else if (mask_nxt[2]) begin
            new_cls = CLS_TRI;
        end

        lock_hit = one_hot && (cnt_nxt >= 4'(LOCK_CNT));
        cls_ok   = sel_cls(cons, wave_type);
        cls_anc  = sel_cls(anc, wave_type);

        // While hunting there is no class yet, so any anchor restarts the
        // meter; the value is never reported before the first locked anchor.
        anc_clr  = (state == LOCK) ? cls_anc : |anc;
        pcnt_inc = (pcnt == 8'd255) ? 8'd255 : pcnt + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HUNT;
            prev       <= 5'd0;
            prev_ok    <= 1'b0;
            last_up    <= 1'b0;
            dir_vld    <= 1'b0;
            mask       <= 3'b111;
            cnt        <= 4'd0;
            pcnt       <= 8'd0;
            armed      <= 1'b0;
            wave_type  <= CLS_UNKNOWN;
            locked     <= 1'b0;
            period     <= 8'd0;
            period_vld <= 1'b0;
            err        <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            err        <= 1'b0;
            if (wave_en) begin
                prev <= wave;
                if (!prev_ok) begin
                    prev_ok <= 1'b1;
                    pcnt    <= pcnt_inc;
                end else begin
                    if (st_up || st_dn) begin
                        last_up <= st_up;
                        dir_vld <= 1'b1;
                    end
                    pcnt <= anc_clr ? 8'd1 : pcnt_inc;
                    mask <= mask_nxt;
                    cnt  <= cnt_nxt;
                    case (state)
                        HUNT: begin
                            if (lock_hit) begin
                                state     <= LOCK;
                                locked    <= 1'b1;
                                wave_type <= new_cls;
                                // An anchor on the locking edge only restarts
                                // the meter; a full period has not been seen.
                                armed     <= 1'b0;
                            end
                        end
                        LOCK: begin
                            if (!cls_ok) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                wave_type <= CLS_UNKNOWN;
                                err       <= 1'b1;
                                armed     <= 1'b0;
                            end else if (cls_anc) begin
                                if (armed) begin
                                    period     <= pcnt;
                                    period_vld <= 1'b1;
                                end
                                armed <= 1'b1;
                            end
                        end
                        default: state <= HUNT;
                    endcase
                end
            end
        end
    end

endmodule
